myfilter_window: RTL and testbench

Windowed, registered successor to the combinational `myfilter` 4-in/4-out block. It filters `WIDTH` independent 1-bit input channels over a sliding window of the last `DEPTH` accepted samples. A run-time `mode` selects majority vote or unanimous debounce. It sits between raw switch/sensor inputs and downstream logic, and delivers a qualified output word with a per-channel change flag.

---
 rtl/myfilter_window.sv | 78 +++++++
 tb/tb_myfilter_window.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/myfilter_window.sv
// Windowed majority / debounce filter over WIDTH independent 1-bit channels.
// Each channel keeps its last DEPTH accepted samples; evaluation is registered one edge after acceptance.
module myfilter_window #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] changed
);

  localparam int                FILL_W    = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam int                HALF      = DEPTH / 2;

  // An even window would allow majority ties, so refuse to build one.
  if (DEPTH < 3 || (DEPTH % 2) == 0) begin : g_bad_depth
    $error("myfilter_window: DEPTH must be odd and >= 3");
  end

  logic [WIDTH-1:0][DEPTH-1:0] hist;
  logic [FILL_W-1:0]           fill;
  logic                        eval;
  logic [WIDTH-1:0]            next_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      eval <= 1'b0;
    end else begin
      eval <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          hist[i] <= {hist[i][DEPTH-2:0], din[i]};
        end
        if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Debounce keeps the old bit unless the whole window agrees.
  always_comb begin
    next_dout = dout;
    for (int i = 0; i < WIDTH; i++) begin
      if (!mode) begin
        next_dout[i] = ($countones(hist[i]) > HALF);
      end else if (&hist[i]) begin
        next_dout[i] = 1'b1;
      end else if (~|hist[i]) begin
        next_dout[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      changed   <= '0;
    end else if (eval && fill == FILL_FULL) begin
      out_valid <= 1'b1;
      dout      <= next_dout;
      changed   <= next_dout ^ dout;
    end else begin
      out_valid <= 1'b0;
      changed   <= '0;
    end
  end

endmodule

// File: tb/tb_myfilter_window.sv
// Scoreboard bench for myfilter_window: directed scenarios on a 4x3 instance, random sweep on an 8x5 instance.
module tb_myfilter_window;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       a_in_valid = 1'b0;
  logic [3:0] a_din = '0;
  logic       a_mode = 1'b0;
  logic       a_out_valid;
  logic [3:0] a_dout;
  logic [3:0] a_changed;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_mode = 1'b0;
  logic       b_out_valid;
  logic [7:0] b_dout;
  logic [7:0] b_changed;

  myfilter_window #(.WIDTH(4), .DEPTH(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .din(a_din), .mode(a_mode),
    .out_valid(a_out_valid), .dout(a_dout), .changed(a_changed)
  );

  myfilter_window #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .din(b_din), .mode(b_mode),
    .out_valid(b_out_valid), .dout(b_dout), .changed(b_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_hist[8];
  int         m_fill;
  bit         m_eval;
  logic [7:0] m_dout;
  int         cur_w;
  int         cur_d;
  bit         sel;
  int         checks = 0;
  int         errors = 0;

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: the evaluation due at the coming edge uses the window as it stands now
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic m);
    logic [7:0] mask;
    logic [7:0] nd;
    int         ones;
    @(negedge clk);
    if (sel == 1'b0) begin
      a_in_valid = v; a_din = d[3:0]; a_mode = m;
    end else begin
      b_in_valid = v; b_din = d; b_mode = m;
    end
    mask = 8'((1 << cur_d) - 1);
    if (m_eval && m_fill == cur_d) begin
      nd = m_dout;
      for (int i = 0; i < cur_w; i++) begin
        ones = $countones(m_hist[i] & mask);
        if (!m) nd[i] = (ones > cur_d / 2);
        else if (ones == cur_d) nd[i] = 1'b1;
        else if (ones == 0) nd[i] = 1'b0;
      end
      sb.push_back('{d: nd, c: nd ^ m_dout});
      m_dout = nd;
    end
    m_eval = v;
    if (v) begin
      for (int i = 0; i < cur_w; i++) m_hist[i] = ((m_hist[i] << 1) | {7'b0, d[i]}) & mask;
      if (m_fill < cur_d) m_fill++;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    logic       ov;
    logic       exp_ov;
    logic [7:0] od;
    logic [7:0] oc;
    exp_t       e;
    if (sel == 1'b0) begin
      ov = a_out_valid; od = {4'b0, a_dout}; oc = {4'b0, a_changed};
    end else begin
      ov = b_out_valid; od = b_dout; oc = b_changed;
    end
    exp_ov = (sb.size() != 0);
    checkValue("out_valid", {7'b0, ov}, {7'b0, exp_ov});
    if (exp_ov) begin
      e = sb.pop_front();
      if (ov) begin
        checkValue("dout", od, e.d);
        checkValue("changed", oc, e.c);
      end
    end else begin
      checkValue("changed_idle", oc, 8'h00);
      checkValue("dout_hold", od, m_dout);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
    m_fill = 0;
    m_eval = 1'b0;
    m_dout = '0;
    sb.delete();
  endtask

  task automatic resetAll();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    modelReset();
    @(negedge clk);
    checkValue("rst_dout", sel ? b_dout : {4'b0, a_dout}, 8'h00);
    checkValue("rst_valid", {7'b0, sel ? b_out_valid : a_out_valid}, 8'h00);
    rst = 1'b0;
  endtask

  task automatic checkA(input string tag, input logic ov, input logic [3:0] d, input logic [3:0] c);
    checkValue({tag, "_ov"}, {7'b0, a_out_valid}, {7'b0, ov});
    checkValue({tag, "_dout"}, {4'b0, a_dout}, {4'b0, d});
    checkValue({tag, "_chg"}, {4'b0, a_changed}, {4'b0, c});
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("[TB] FAIL timeout cycle budget exhausted");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses;
    logic [7:0] r;
    sel = 1'b0; cur_w = 4; cur_d = 3;
    modelReset();

    // Warm-up: two silent samples, the third produces the first pulse
    resetAll();
    applyStimulus(1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    checkA("warm1", 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    checkA("warm2", 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkA("warm3", 1'b1, 4'hF, 4'hF);

    // Majority vote
    resetAll();
    applyStimulus(1'b1, 8'h0A, 1'b0);
    applyStimulus(1'b1, 8'h0C, 1'b0);
    applyStimulus(1'b1, 8'h09, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkA("maj1", 1'b1, 4'h8, 4'h8);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkA("maj2", 1'b1, 4'h8, 4'h0);

    // Gaps hold everything, then a single sample gives a single pulse
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      pulses += int'(a_out_valid);
    end
    checkValue("gap_pulses", 8'(pulses), 8'd0);
    checkValue("gap_dout", {4'b0, a_dout}, 8'h08);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkA("gap_one", 1'b1, 4'h1, 4'h9);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkValue("gap_after", {7'b0, a_out_valid}, 8'h00);

    // Debounce: no unanimous channel holds the reset value
    resetAll();
    applyStimulus(1'b1, 8'h08, 1'b1);
    applyStimulus(1'b1, 8'h07, 1'b1);
    applyStimulus(1'b1, 8'h08, 1'b1);
    applyStimulus(1'b1, 8'h07, 1'b1);
    checkA("deb1", 1'b1, 4'h0, 4'h0);
    applyStimulus(1'b1, 8'h07, 1'b1);
    checkA("deb2", 1'b1, 4'h0, 4'h0);
    applyStimulus(1'b1, 8'h07, 1'b1);
    checkA("deb3", 1'b1, 4'h0, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkA("deb4", 1'b1, 4'h7, 4'h7);

    // Reset between acceptance and evaluation cancels the pending pulse
    applyStimulus(1'b1, 8'h0F, 1'b0);
    #1;
    rst = 1'b1;
    a_in_valid = 1'b0;
    modelReset();
    #1;
    checkA("mid_rst", 1'b0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    checkA("mid_edge", 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    checkValue("rewarm_none", {7'b0, a_out_valid}, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkA("rewarm", 1'b1, 4'hF, 4'hF);

    // Random sweep on the 8-channel, 5-deep instance
    sel = 1'b1; cur_w = 8; cur_d = 5;
    resetAll();
    r = 8'($urandom);
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 1) == 0) r = 8'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
